// File: rtl/team_08_touch_seq.sv
// rtl/team_08_touch_seq.sv - I2C burst-read sequencer for the FT6x06-class touch controller
// Optional feature macro: TOUCH_NACK_RETRY_EN (restart the transfer after an address/register NACK, up to 3 retries)
module team_08_touch_seq #(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = 7'h38,
    parameter logic [7:0] REG_ADDR = 8'h02
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en,
    input  logic        int_n,
    input  logic        sda_in,
    input  logic        scl_in,
    output logic        sda_oeb,
    output logic        scl_oeb,
    output logic        sda_out,
    output logic        scl_out,
    output logic        busy,
    output logic        data_valid,
    output logic        nack_err,
    output logic [3:0]  touch_cnt,
    output logic [1:0]  touch_evt,
    output logic [11:0] touch_x,
    output logic [11:0] touch_y
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_ACK1, S_REG, S_ACK2, S_RSTART,
        S_ADDR_R, S_ACK3, S_RD, S_MACK, S_STOP, S_DONE
    } state_t;

    localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

    state_t      state;
    logic [9:0]  qcnt;
    logic [1:0]  phase;
    logic [2:0]  bit_cnt;
    logic [2:0]  byte_idx;
    logic [7:0]  tx_byte;
    // Only the bits that reach touch_* are kept; STATUS[7:4] shift out the top.
    logic [35:0] rx;
    logic        sda_smp;
    logic        pending;
    logic        aborted;
    logic        nacked;
`ifdef TOUCH_NACK_RETRY_EN
    logic [1:0]  retry_cnt;
`endif
    logic [2:0]  int_sync;
    logic        int_fall;
    logic        hold;
    logic        sda_rel_c;
    logic        scl_rel_c;
    logic        scl_mid;

    // Open-drain pads: the output value is always low, only the enables move.
    assign sda_out = 1'b0;
    assign scl_out = 1'b0;

    assign int_fall = int_sync[2] & ~int_sync[1];
    // A slave holding SCL low while we release it freezes the bit timer.
    assign hold     = scl_oeb & ~scl_in;
    assign scl_mid  = (phase == 2'd1) || (phase == 2'd2);

    // Two-flop synchronizer on the interrupt plus one extra stage for edge detect.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            int_sync <= 3'b111;
        end else begin
            int_sync <= {int_sync[1:0], int_n};
        end
    end

    // Line levels wanted for the current state and quarter phase (1 = release).
    always_comb begin
        sda_rel_c = 1'b1;
        scl_rel_c = 1'b1;
        case (state)
            S_START: begin
                scl_rel_c = (phase != 2'd3);
                sda_rel_c = (phase < 2'd2);
            end
            S_RSTART: begin
                scl_rel_c = scl_mid;
                sda_rel_c = (phase < 2'd2);
            end
            S_STOP: begin
                scl_rel_c = (phase != 2'd0);
                sda_rel_c = (phase == 2'd3);
            end
            S_ADDR_W, S_REG, S_ADDR_R: begin
                scl_rel_c = scl_mid;
                sda_rel_c = tx_byte[3'd7 - bit_cnt];
            end
            S_ACK1, S_ACK2, S_ACK3, S_RD: begin
                scl_rel_c = scl_mid;
                sda_rel_c = 1'b1;
            end
            S_MACK: begin
                scl_rel_c = scl_mid;
                sda_rel_c = (byte_idx == 3'd4);
            end
            default: begin
                sda_rel_c = 1'b1;
                scl_rel_c = 1'b1;
            end
        endcase
    end

    // Sequencer: bit timer, transfer FSM, interrupt queueing and registered outputs.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            qcnt       <= 10'd0;
            phase      <= 2'd0;
            bit_cnt    <= 3'd0;
            byte_idx   <= 3'd0;
            tx_byte    <= 8'd0;
            rx         <= 36'd0;
            sda_smp    <= 1'b1;
            pending    <= 1'b0;
            aborted    <= 1'b0;
            nacked     <= 1'b0;
`ifdef TOUCH_NACK_RETRY_EN
            retry_cnt  <= 2'd0;
`endif
            sda_oeb    <= 1'b1;
            scl_oeb    <= 1'b1;
            busy       <= 1'b0;
            data_valid <= 1'b0;
            nack_err   <= 1'b0;
            touch_cnt  <= 4'd0;
            touch_evt  <= 2'd0;
            touch_x    <= 12'd0;
            touch_y    <= 12'd0;
        end else begin
            data_valid <= 1'b0;
            nack_err   <= 1'b0;
            sda_oeb    <= sda_rel_c;
            scl_oeb    <= scl_rel_c;

            if (state == S_IDLE) begin
                qcnt  <= 10'd0;
                phase <= 2'd0;
                if (pending && en) begin
                    pending <= 1'b0;
                    aborted <= 1'b0;
                    nacked  <= 1'b0;
`ifdef TOUCH_NACK_RETRY_EN
                    retry_cnt <= 2'd0;
`endif
                    busy    <= 1'b1;
                    state   <= S_START;
                end
            end else if (state == S_DONE) begin
                state <= S_IDLE;
            end else if (!hold) begin
                if (qcnt != QMAX) begin
                    qcnt <= qcnt + 10'd1;
                end else begin
                    qcnt  <= 10'd0;
                    phase <= phase + 2'd1;
                    if (phase == 2'd2) begin
                        sda_smp <= sda_in;
                    end
                    if (phase == 2'd3) begin
                        case (state)
                            S_START: begin
                                tx_byte <= {DEV_ADDR, 1'b0};
                                bit_cnt <= 3'd0;
                                state   <= S_ADDR_W;
                            end
                            S_ADDR_W, S_REG, S_ADDR_R: begin
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    state <= (state == S_ADDR_W) ? S_ACK1 :
                                             (state == S_REG)    ? S_ACK2 : S_ACK3;
                                end
                            end
                            S_ACK1, S_ACK2, S_ACK3: begin
                                bit_cnt <= 3'd0;
                                if (sda_smp) begin
                                    nack_err <= 1'b1;
                                    nacked   <= 1'b1;
                                    state    <= S_STOP;
                                end else if (state == S_ACK1) begin
                                    tx_byte <= REG_ADDR;
                                    state   <= S_REG;
                                end else if (state == S_ACK2) begin
                                    state <= S_RSTART;
                                end else begin
                                    byte_idx <= 3'd0;
                                    state    <= S_RD;
                                end
                            end
                            S_RSTART: begin
                                tx_byte <= {DEV_ADDR, 1'b1};
                                bit_cnt <= 3'd0;
                                state   <= S_ADDR_R;
                            end
                            S_RD: begin
                                rx      <= {rx[34:0], sda_smp};
                                bit_cnt <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    state <= S_MACK;
                                end
                            end
                            S_MACK: begin
                                if (byte_idx == 3'd4) begin
                                    state <= S_STOP;
                                end else begin
                                    byte_idx <= byte_idx + 3'd1;
                                    bit_cnt  <= 3'd0;
                                    state    <= S_RD;
                                end
                            end
                            S_STOP: begin
                                if (aborted || nacked) begin
`ifdef TOUCH_NACK_RETRY_EN
                                    if (nacked && !aborted && en && (retry_cnt != 2'd3)) begin
                                        retry_cnt <= retry_cnt + 2'd1;
                                        nacked    <= 1'b0;
                                        state     <= S_START;
                                    end else begin
                                        busy  <= 1'b0;
                                        state <= S_IDLE;
                                    end
`else
                                    busy  <= 1'b0;
                                    state <= S_IDLE;
`endif
                                end else begin
                                    touch_cnt  <= rx[35:32];
                                    touch_evt  <= rx[31:30];
                                    touch_x    <= {rx[27:24], rx[23:16]};
                                    touch_y    <= {rx[11:8], rx[7:0]};
                                    data_valid <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= S_DONE;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                        // Enable loss: the bit just finished, now close the bus and forget queued work.
                        if (!en && (state != S_STOP)) begin
                            aborted <= 1'b1;
                            pending <= 1'b0;
                            state   <= S_STOP;
                        end
                    end
                end
            end

            // Falling interrupt edges queue one transfer; repeats merge into it.
            if (int_fall && en) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_team_08_touch_seq.sv
// tb/tb_team_08_touch_seq.sv - directed bench for team_08_touch_seq with a behavioural I2C slave
module tb_team_08_touch_seq;

    localparam int CLK_DIV  = 4;
    localparam int NOM_CLKS = 75 * 4 * CLK_DIV;
`ifdef TOUCH_NACK_RETRY_EN
    localparam int EXP_TRIES = 4;
`else
    localparam int EXP_TRIES = 1;
`endif
    localparam int M_IDLE = 0;
    localparam int M_RX   = 1;
    localparam int M_ACK  = 2;
    localparam int M_TX   = 3;
    localparam int M_MACK = 4;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic en = 1'b1;
    logic int_n = 1'b1;
    logic sda_oeb, scl_oeb, sda_out, scl_out, busy, data_valid, nack_err;
    logic [3:0]  touch_cnt;
    logic [1:0]  touch_evt;
    logic [11:0] touch_x, touch_y;
    logic sda_line, scl_line;

    logic slave_sda = 1'b1;
    logic hold = 1'b0;
    logic present = 1'b1;
    logic stretch_en = 1'b0;
    logic [7:0] rd_tbl [5];

    int mode = 0, nbit = 0, rd_idx = 0;
    logic [7:0] shreg = 8'd0, cur = 8'd0;
    logic first = 1'b0, rw = 1'b0, ack = 1'b0, mack_val = 1'b1;
    logic scl_p = 1'b1, sda_p = 1'b1, snap_sda = 1'b1;
    int st_state = 0, st_cnt = 0, st_bad = 0;
    int start_cnt = 0, stop_cnt = 0, rx_n = 0, mack_n = 0, dv_cnt = 0, nack_cnt = 0;
    logic [7:0] rx_log [256];
    logic       mack_log [256];

    int cmp_n = 0;
    int fail_n = 0;

    assign sda_line = sda_oeb & slave_sda;
    assign scl_line = scl_oeb & ~hold;

    always #5 clk = ~clk;

    team_08_touch_seq #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h38), .REG_ADDR(8'h02)) dut (
        .clk(clk), .nrst(nrst), .en(en), .int_n(int_n),
        .sda_in(sda_line), .scl_in(scl_line),
        .sda_oeb(sda_oeb), .scl_oeb(scl_oeb), .sda_out(sda_out), .scl_out(scl_out),
        .busy(busy), .data_valid(data_valid), .nack_err(nack_err),
        .touch_cnt(touch_cnt), .touch_evt(touch_evt), .touch_x(touch_x), .touch_y(touch_y)
    );

    // Slave at 0x38, bus monitor, clock-stretch injector and pulse counters.
    always @(negedge clk) begin
        if (data_valid) dv_cnt++;
        if (nack_err) nack_cnt++;
        if (!nrst) begin
            mode = M_IDLE; slave_sda = 1'b1; scl_p = 1'b1; sda_p = 1'b1;
        end else begin
            if (scl_line && scl_p && sda_p && !sda_line) begin
                start_cnt++; mode = M_RX; nbit = 0; first = 1'b1; slave_sda = 1'b1;
            end else if (scl_line && scl_p && !sda_p && sda_line) begin
                stop_cnt++; mode = M_IDLE; slave_sda = 1'b1;
            end else if (scl_line && !scl_p) begin
                if (mode == M_RX) begin shreg = {shreg[6:0], sda_line}; nbit++; end
                else if (mode == M_TX) nbit++;
                else if (mode == M_MACK) mack_val = sda_line;
            end else if (!scl_line && scl_p) begin
                if (mode == M_RX && nbit == 8) begin
                    rx_log[rx_n & 255] = shreg; rx_n++;
                    if (first) begin
                        ack = present && (shreg[7:1] == 7'h38);
                        rw = shreg[0];
                        rd_idx = 0;
                    end else ack = 1'b1;
                    first = 1'b0;
                    if (ack) begin slave_sda = 1'b0; mode = M_ACK; end
                    else mode = M_IDLE;
                end else if (mode == M_ACK) begin
                    slave_sda = 1'b1; nbit = 0;
                    if (rw) begin cur = rd_tbl[rd_idx]; slave_sda = cur[7]; mode = M_TX; end
                    else mode = M_RX;
                end else if (mode == M_TX) begin
                    if (nbit == 8) begin slave_sda = 1'b1; mode = M_MACK; end
                    else slave_sda = cur[7 - nbit];
                end else if (mode == M_MACK) begin
                    mack_log[mack_n & 255] = mack_val; mack_n++;
                    if (!mack_val && rd_idx < 4) begin
                        rd_idx++;
                        if (stretch_en && rd_idx == 2 && st_state == 0) begin hold = 1'b1; st_state = 1; end
                        cur = rd_tbl[rd_idx]; slave_sda = cur[7]; nbit = 0; mode = M_TX;
                    end else mode = M_IDLE;
                end
            end
            scl_p = scl_line;
            sda_p = sda_line;
        end
        if (st_state == 1 && scl_oeb) begin
            st_state = 2; st_cnt = 0; snap_sda = sda_oeb;
        end else if (st_state == 2) begin
            if (sda_oeb !== snap_sda || scl_oeb !== 1'b1) st_bad++;
            st_cnt++;
            if (st_cnt == 50) begin hold = 1'b0; st_state = 3; end
        end
    end

    task automatic wait_busy(input logic val, input int limit, output int clks, output bit ok);
        clks = 0;
        while (busy !== val && clks < limit) begin
            @(negedge clk);
            clks++;
        end
        ok = (busy === val);
    endtask

    task automatic pulse_int();
        int_n = 1'b0;
        repeat (4) @(negedge clk);
        int_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_read(input int limit, output int dur, output bit ok);
        int c;
        bit ok1, ok2;
        int_n = 1'b0;
        wait_busy(1'b1, 50, c, ok1);
        int_n = 1'b1;
        wait_busy(1'b0, limit, dur, ok2);
        ok = ok1 & ok2;
    endtask

    task automatic set_tbl(input logic [7:0] b0, b1, b2, b3, b4);
        rd_tbl[0] = b0; rd_tbl[1] = b1; rd_tbl[2] = b2; rd_tbl[3] = b3; rd_tbl[4] = b4;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            int_n = i[0];
            @(negedge clk);
        end
        cmp_n++; if (sda_oeb !== 1'b1) begin fail_n++; $display("FAIL reset_sda_oeb got %b want 1", sda_oeb); end
        cmp_n++; if (scl_oeb !== 1'b1) begin fail_n++; $display("FAIL reset_scl_oeb got %b want 1", scl_oeb); end
        cmp_n++; if (busy !== 1'b0) begin fail_n++; $display("FAIL reset_busy got %b want 0", busy); end
        cmp_n++; if ({data_valid, nack_err, sda_out, scl_out} !== 4'b0000) begin fail_n++;
            $display("FAIL reset_pulses got %b want 0000", {data_valid, nack_err, sda_out, scl_out}); end
        cmp_n++; if ({touch_cnt, touch_evt, touch_x, touch_y} !== 30'd0) begin fail_n++;
            $display("FAIL reset_touch got %h want 0", {touch_cnt, touch_evt, touch_x, touch_y}); end
        int_n = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        repeat (30) @(negedge clk);
        cmp_n++; if (busy !== 1'b0) begin fail_n++; $display("FAIL reset_no_start got busy=%b want 0", busy); end
    endtask

    task automatic test_nominal();
        int dur, rx0, mk0, dv0;
        bit ok;
        set_tbl(8'h01, 8'h42, 8'hA5, 8'h83, 8'h3C);
        rx0 = rx_n; mk0 = mack_n; dv0 = dv_cnt;
        do_read(3000, dur, ok);
        repeat (5) @(negedge clk);
        cmp_n++; if (!ok) begin fail_n++; $display("FAIL nom_timeout busy=%b", busy); end
        cmp_n++; if (rx_n - rx0 != 3) begin fail_n++; $display("FAIL nom_byte_count got %0d want 3", rx_n - rx0); end
        cmp_n++; if ({rx_log[rx0 & 255], rx_log[(rx0 + 1) & 255], rx_log[(rx0 + 2) & 255]} !== 24'h700271) begin fail_n++;
            $display("FAIL nom_bus_bytes got %h want 700271",
                     {rx_log[rx0 & 255], rx_log[(rx0 + 1) & 255], rx_log[(rx0 + 2) & 255]}); end
        cmp_n++; if ({mack_log[mk0 & 255], mack_log[(mk0 + 1) & 255], mack_log[(mk0 + 2) & 255],
                      mack_log[(mk0 + 3) & 255], mack_log[(mk0 + 4) & 255]} !== 5'b00001) begin fail_n++;
            $display("FAIL nom_master_acks got %b want 00001", {mack_log[mk0 & 255], mack_log[(mk0 + 1) & 255],
                     mack_log[(mk0 + 2) & 255], mack_log[(mk0 + 3) & 255], mack_log[(mk0 + 4) & 255]}); end
        cmp_n++; if (dv_cnt - dv0 != 1) begin fail_n++; $display("FAIL nom_dv_pulses got %0d want 1", dv_cnt - dv0); end
        cmp_n++; if (touch_cnt !== 4'd1) begin fail_n++; $display("FAIL nom_touch_cnt got %h want 1", touch_cnt); end
        cmp_n++; if (touch_evt !== 2'd1) begin fail_n++; $display("FAIL nom_touch_evt got %h want 1", touch_evt); end
        cmp_n++; if (touch_x !== 12'h2A5) begin fail_n++; $display("FAIL nom_touch_x got %h want 2a5", touch_x); end
        cmp_n++; if (touch_y !== 12'h33C) begin fail_n++; $display("FAIL nom_touch_y got %h want 33c", touch_y); end
        cmp_n++; if (dur < NOM_CLKS - 2 || dur > NOM_CLKS + 2) begin fail_n++;
            $display("FAIL nom_duration got %0d want %0d", dur, NOM_CLKS); end
    endtask

    task automatic test_nack();
        int dur, dv0, nk0, st0, sp0;
        bit ok;
        present = 1'b0;
        dv0 = dv_cnt; nk0 = nack_cnt; st0 = start_cnt; sp0 = stop_cnt;
        do_read(5000, dur, ok);
        repeat (50) @(negedge clk);
        cmp_n++; if (!ok || busy !== 1'b0) begin fail_n++; $display("FAIL nack_idle got busy=%b want 0", busy); end
        cmp_n++; if (nack_cnt - nk0 != EXP_TRIES) begin fail_n++;
            $display("FAIL nack_pulses got %0d want %0d", nack_cnt - nk0, EXP_TRIES); end
        cmp_n++; if (start_cnt - st0 != EXP_TRIES) begin fail_n++;
            $display("FAIL nack_starts got %0d want %0d", start_cnt - st0, EXP_TRIES); end
        cmp_n++; if (stop_cnt - sp0 != EXP_TRIES) begin fail_n++;
            $display("FAIL nack_stops got %0d want %0d", stop_cnt - sp0, EXP_TRIES); end
        cmp_n++; if (dv_cnt - dv0 != 0) begin fail_n++; $display("FAIL nack_dv got %0d want 0", dv_cnt - dv0); end
        cmp_n++; if ({touch_cnt, touch_evt, touch_x, touch_y} !== {4'd1, 2'd1, 12'h2A5, 12'h33C}) begin fail_n++;
            $display("FAIL nack_touch_kept got %h want %h", {touch_cnt, touch_evt, touch_x, touch_y},
                     {4'd1, 2'd1, 12'h2A5, 12'h33C}); end
        present = 1'b1;
    endtask

    task automatic test_stretch();
        int dur, bad0;
        bit ok;
        set_tbl(8'h05, 8'hC1, 8'h23, 8'h0F, 8'hFF);
        bad0 = st_bad;
        stretch_en = 1'b1;
        do_read(4000, dur, ok);
        stretch_en = 1'b0;
        repeat (5) @(negedge clk);
        cmp_n++; if (!ok) begin fail_n++; $display("FAIL str_timeout busy=%b", busy); end
        cmp_n++; if (st_state != 3) begin fail_n++; $display("FAIL str_applied got state %0d want 3", st_state); end
        cmp_n++; if (st_bad - bad0 != 0) begin fail_n++; $display("FAIL str_lines_moved got %0d want 0", st_bad - bad0); end
        cmp_n++; if (dur < NOM_CLKS + 48 || dur > NOM_CLKS + 52) begin fail_n++;
            $display("FAIL str_duration got %0d want %0d", dur, NOM_CLKS + 50); end
        cmp_n++; if ({touch_cnt, touch_evt, touch_x, touch_y} !== {4'd5, 2'd3, 12'h123, 12'hFFF}) begin fail_n++;
            $display("FAIL str_touch got %h want %h", {touch_cnt, touch_evt, touch_x, touch_y},
                     {4'd5, 2'd3, 12'h123, 12'hFFF}); end
    endtask

    task automatic test_back_to_back();
        int dv0, sp0;
        set_tbl(8'h01, 8'h42, 8'hA5, 8'h83, 8'h3C);
        dv0 = dv_cnt; sp0 = stop_cnt;
        pulse_int();
        repeat (300) @(negedge clk);
        pulse_int();
        repeat (300) @(negedge clk);
        pulse_int();
        repeat (3000) @(negedge clk);
        cmp_n++; if (dv_cnt - dv0 != 2) begin fail_n++; $display("FAIL b2b_dv_pulses got %0d want 2", dv_cnt - dv0); end
        cmp_n++; if (stop_cnt - sp0 != 2) begin fail_n++; $display("FAIL b2b_stops got %0d want 2", stop_cnt - sp0); end
        cmp_n++; if (busy !== 1'b0) begin fail_n++; $display("FAIL b2b_idle got busy=%b want 0", busy); end
        cmp_n++; if (touch_x !== 12'h2A5 || touch_y !== 12'h33C) begin fail_n++;
            $display("FAIL b2b_touch got x=%h y=%h want 2a5 33c", touch_x, touch_y); end
    endtask

    task automatic test_en_drop();
        int c, dur, dv0, sp0;
        bit ok;
        set_tbl(8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        dv0 = dv_cnt; sp0 = stop_cnt;
        int_n = 1'b0;
        c = 0;
        while (!(mode == M_TX && rd_idx == 1 && nbit == 3) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        int_n = 1'b1;
        cmp_n++; if (c >= 2000) begin fail_n++; $display("FAIL endrop_reach_rd1 got %0d clks want <2000", c); end
        en = 1'b0;
        wait_busy(1'b0, 40, c, ok);
        repeat (10) @(negedge clk);
        cmp_n++; if (!ok) begin fail_n++; $display("FAIL endrop_stop_latency got busy=%b after %0d clks want 0", busy, c); end
        cmp_n++; if (stop_cnt - sp0 != 1) begin fail_n++; $display("FAIL endrop_stop got %0d want 1", stop_cnt - sp0); end
        cmp_n++; if (dv_cnt - dv0 != 0) begin fail_n++; $display("FAIL endrop_dv got %0d want 0", dv_cnt - dv0); end
        cmp_n++; if (touch_x !== 12'h2A5 || touch_cnt !== 4'd1) begin fail_n++;
            $display("FAIL endrop_touch_kept got x=%h cnt=%h want 2a5 1", touch_x, touch_cnt); end
        repeat (100) @(negedge clk);
        cmp_n++; if (busy !== 1'b0) begin fail_n++; $display("FAIL endrop_no_restart got busy=%b want 0", busy); end
        en = 1'b1;
        repeat (4) @(negedge clk);
        set_tbl(8'h02, 8'h80, 8'h10, 8'h40, 8'h20);
        dv0 = dv_cnt;
        do_read(3000, dur, ok);
        repeat (5) @(negedge clk);
        cmp_n++; if (!ok || dv_cnt - dv0 != 1) begin fail_n++;
            $display("FAIL endrop_fresh_dv got %0d ok=%0d want 1", dv_cnt - dv0, ok); end
        cmp_n++; if ({touch_cnt, touch_evt, touch_x, touch_y} !== {4'd2, 2'd2, 12'h010, 12'h020}) begin fail_n++;
            $display("FAIL endrop_fresh_touch got %h want %h", {touch_cnt, touch_evt, touch_x, touch_y},
                     {4'd2, 2'd2, 12'h010, 12'h020}); end
    endtask

    initial begin
        set_tbl(8'h01, 8'h42, 8'hA5, 8'h83, 8'h3C);
        test_reset();
        test_nominal();
        test_nack();
        test_stretch();
        test_back_to_back();
        test_en_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
        $finish;
    end

endmodule
